// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
// N-master to 1-slave AXI4-Lite arbiter with a single outstanding transaction.
// The grant is decided in IDLE (one cycle), then held through the address,
// data and response phases of exactly one read or one write.
// A master presenting both AW and AR is served write first.
// Optional feature: define AXI_ARB_ROUND_ROBIN_EN for round-robin selection;
// the default build uses fixed priority with the highest index winning.
module axi_lite_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic                             clk,
    input  logic                             reset,

    // requester side, one lane per master
    input  logic [NUM_MASTERS-1:0]           m_arvalid,
    input  logic [NUM_MASTERS-1:0][31:0]     m_araddr,
    output logic [NUM_MASTERS-1:0]           m_arready,
    output logic [NUM_MASTERS-1:0]           m_rvalid,
    output logic [NUM_MASTERS-1:0][31:0]     m_rdata,
    output logic [NUM_MASTERS-1:0][1:0]      m_rresp,
    input  logic [NUM_MASTERS-1:0]           m_rready,
    input  logic [NUM_MASTERS-1:0]           m_awvalid,
    input  logic [NUM_MASTERS-1:0][31:0]     m_awaddr,
    output logic [NUM_MASTERS-1:0]           m_awready,
    input  logic [NUM_MASTERS-1:0]           m_wvalid,
    input  logic [NUM_MASTERS-1:0][31:0]     m_wdata,
    input  logic [NUM_MASTERS-1:0][3:0]      m_wmask,
    output logic [NUM_MASTERS-1:0]           m_wready,
    output logic [NUM_MASTERS-1:0]           m_bvalid,
    output logic [NUM_MASTERS-1:0][1:0]      m_bresp,
    input  logic [NUM_MASTERS-1:0]           m_bready,

    // downstream bus
    output logic                             s_arvalid,
    output logic [31:0]                      s_araddr,
    input  logic                             s_arready,
    input  logic                             s_rvalid,
    input  logic [31:0]                      s_rdata,
    input  logic [1:0]                       s_rresp,
    output logic                             s_rready,
    output logic                             s_awvalid,
    output logic [31:0]                      s_awaddr,
    input  logic                             s_awready,
    output logic                             s_wvalid,
    output logic [31:0]                      s_wdata,
    output logic [3:0]                       s_wmask,
    input  logic                             s_wready,
    input  logic                             s_bvalid,
    input  logic [1:0]                       s_bresp,
    output logic                             s_bready,

    output logic [NUM_MASTERS-1:0]           grant,
    output logic                             busy
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;

    logic [2:0]             state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;     // binary form of grant_reg
    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_req;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       rr_reg, rr_next;
`endif

    // a master requests when it shows either an address read or write
    assign req     = m_arvalid | m_awvalid;
    assign any_req = |req;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // round-robin: first requester found scanning upward from rr_reg
    always_comb begin
        int  cand;
        logic found;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(rr_reg) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end
`else
    // fixed priority: the highest-index requester wins
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (req[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

    // next-state logic: arbitrate in IDLE, then walk one transaction's phases
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        rr_next    = rr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next = NUM_MASTERS'(1) << win_idx;
                    idx_next   = win_idx;
                    state_next = m_awvalid[win_idx] ? WR_ADDR : RD_ADDR;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                    rr_next    = (int'(win_idx) + 1 >= NUM_MASTERS) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            RD_ADDR: begin
                if (m_arvalid[idx_reg] && s_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_rvalid && m_rready[idx_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            WR_ADDR: begin
                if (m_awvalid[idx_reg] && s_awready) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                if (m_wvalid[idx_reg] && s_wready) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_bvalid && m_bready[idx_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // state, grant and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_reg    <= rr_next;
`endif
        end
    end

    logic st_rd_addr, st_rd_data, st_wr_addr, st_wr_data, st_wr_resp;
    assign st_rd_addr = (state_reg == RD_ADDR);
    assign st_rd_data = (state_reg == RD_DATA);
    assign st_wr_addr = (state_reg == WR_ADDR);
    assign st_wr_data = (state_reg == WR_DATA);
    assign st_wr_resp = (state_reg == WR_RESP);

    // downstream side: only the active phase of the granted master is forwarded
    always_comb begin
        s_arvalid = st_rd_addr & m_arvalid[idx_reg];
        s_araddr  = st_rd_addr ? m_araddr[idx_reg] : '0;
        s_rready  = st_rd_data & m_rready[idx_reg];
        s_awvalid = st_wr_addr & m_awvalid[idx_reg];
        s_awaddr  = st_wr_addr ? m_awaddr[idx_reg] : '0;
        s_wvalid  = st_wr_data & m_wvalid[idx_reg];
        s_wdata   = st_wr_data ? m_wdata[idx_reg] : '0;
        s_wmask   = st_wr_data ? m_wmask[idx_reg] : '0;
        s_bready  = st_wr_resp & m_bready[idx_reg];
    end

    // requester side: ungranted lanes see all-zero ready/valid/payload
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
            assign m_arready[gi] = st_rd_addr & grant_reg[gi] & s_arready;
            assign m_rvalid[gi]  = st_rd_data & grant_reg[gi] & s_rvalid;
            assign m_rdata[gi]   = (st_rd_data & grant_reg[gi]) ? s_rdata : '0;
            assign m_rresp[gi]   = (st_rd_data & grant_reg[gi]) ? s_rresp : '0;
            assign m_awready[gi] = st_wr_addr & grant_reg[gi] & s_awready;
            assign m_wready[gi]  = st_wr_data & grant_reg[gi] & s_wready;
            assign m_bvalid[gi]  = st_wr_resp & grant_reg[gi] & s_bvalid;
            assign m_bresp[gi]   = (st_wr_resp & grant_reg[gi]) ? s_bresp : '0;
        end
    endgenerate

    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed testbench for axi_lite_arbiter (two masters).
// Expectations follow the build configuration: AXI_ARB_ROUND_ROBIN_EN
// selects round-robin expectations, otherwise fixed priority (m[1] wins).
module tb_axi_lite_arbiter;

    localparam int N = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N-1:0][31:0] m_araddr, m_rdata;
    logic [N-1:0][1:0]  m_rresp, m_bresp;
    logic [N-1:0]       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N-1:0][31:0] m_awaddr, m_wdata;
    logic [N-1:0][3:0]  m_wmask;
    logic               s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0]        s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [1:0]         s_rresp, s_bresp;
    logic               s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [3:0]         s_wmask;
    logic [N-1:0]       grant;
    logic               busy;

    int total = 0;
    int bad   = 0;

    axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // advance one cycle; inputs are driven and outputs sampled 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_araddr = '0; m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wmask = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_arvalid[0] = 1'b1;
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL reset_s_arvalid got=%b want=0", s_arvalid); end
        reset = 1'b0;
        m_arvalid = '0;
        tick();
        $display("txn reset: busy=%b grant=%b", busy, grant);
    endtask

    task automatic test_single_read();
        clear_inputs();
        m_arvalid[0] = 1'b1; m_araddr[0] = 32'h8000_0000; m_rready[0] = 1'b1; s_arready = 1'b1;
        #1;
        total++; if (s_arvalid !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL rd_idle_quiet got arvalid=%b grant=%b want 0/00", s_arvalid, grant); end
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b want=01", grant); end
        total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) begin bad++; $display("FAIL rd_s_ar got v=%b a=%h want 1/80000000", s_arvalid, s_araddr); end
        total++; if (m_arready !== 2'b01) begin bad++; $display("FAIL rd_arready got=%b want=01", m_arready); end
        tick();
        m_arvalid = '0; s_arready = 1'b0;
        #1;
        total++; if (s_arvalid !== 1'b0 || s_rready !== 1'b1 || m_rvalid !== 2'b00) begin bad++; $display("FAIL rd_wait got arv=%b rr=%b rv=%b want 0/1/00", s_arvalid, s_rready, m_rvalid); end
        tick();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (m_rvalid !== 2'b01) begin bad++; $display("FAIL rd_rvalid got=%b want=01", m_rvalid); end
        total++; if (m_rdata[0] !== 32'hDEAD_BEEF || m_rresp[0] !== 2'b00) begin bad++; $display("FAIL rd_rdata got=%h/%b want=deadbeef/00", m_rdata[0], m_rresp[0]); end
        total++; if (m_rdata[1] !== 32'h0 || grant !== 2'b01) begin bad++; $display("FAIL rd_other_lane got rdata1=%h grant=%b want 0/01", m_rdata[1], grant); end
        tick();
        s_rvalid = 1'b0; s_rdata = '0;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rd_done got grant=%b busy=%b want 00/0", grant, busy); end
        $display("txn read m0 addr=80000000 data=deadbeef");
    endtask

    task automatic test_write();
        clear_inputs();
        m_awvalid[1] = 1'b1; m_awaddr[1] = 32'ha000_03f8;
        m_wvalid[1] = 1'b1; m_wdata[1] = 32'h41; m_wmask[1] = 4'h1; m_bready[1] = 1'b1;
        s_awready = 1'b1;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL wr_grant got=%b want=10", grant); end
        total++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'ha000_03f8 || s_wvalid !== 1'b0) begin bad++; $display("FAIL wr_aw got v=%b a=%h wv=%b want 1/a00003f8/0", s_awvalid, s_awaddr, s_wvalid); end
        total++; if (m_awready !== 2'b10) begin bad++; $display("FAIL wr_awready got=%b want=10", m_awready); end
        tick();
        m_awvalid = '0; s_awready = 1'b0; s_wready = 1'b1;
        #1;
        total++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b1 || s_wdata !== 32'h41 || s_wmask !== 4'h1) begin bad++; $display("FAIL wr_w got awv=%b wv=%b d=%h m=%h want 0/1/41/1", s_awvalid, s_wvalid, s_wdata, s_wmask); end
        total++; if (m_wready !== 2'b10) begin bad++; $display("FAIL wr_wready got=%b want=10", m_wready); end
        tick();
        m_wvalid = '0; s_wready = 1'b0; s_bvalid = 1'b1;
        #1;
        total++; if (m_bvalid !== 2'b10 || m_bresp[1] !== 2'b00 || s_bready !== 1'b1) begin bad++; $display("FAIL wr_b got bv=%b br=%b bready=%b want 10/00/1", m_bvalid, m_bresp[1], s_bready); end
        total++; if ({m_arready[0], m_awready[0], m_wready[0], m_rvalid[0], m_bvalid[0]} !== 5'b0) begin bad++; $display("FAIL wr_m0_quiet got=%b want=00000", {m_arready[0], m_awready[0], m_wready[0], m_rvalid[0], m_bvalid[0]}); end
        tick();
        s_bvalid = 1'b0;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL wr_done got grant=%b busy=%b want 00/0", grant, busy); end
        $display("txn write m1 addr=a00003f8 data=41 mask=1");
    endtask

    task automatic test_contention();
        logic [1:0] first_g, second_g;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        first_g = 2'b01; second_g = 2'b10;
`else
        first_g = 2'b10; second_g = 2'b01;
`endif
        clear_inputs();
        do_reset();
        m_arvalid = 2'b11; m_araddr[0] = 32'h1000; m_araddr[1] = 32'h2000; m_rready = 2'b11;
        s_arready = 1'b1;
        tick();
        total++; if (grant !== first_g) begin bad++; $display("FAIL cont_first got=%b want=%b", grant, first_g); end
        tick();
        m_arvalid = m_arvalid & ~first_g;
        s_rvalid = 1'b1; s_rdata = 32'h1111;
        #1;
        total++; if (m_rvalid !== first_g) begin bad++; $display("FAIL cont_first_r got=%b want=%b", m_rvalid, first_g); end
        tick();
        s_rvalid = 1'b0;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL cont_bubble got=%b want=00", grant); end
        tick();
        total++; if (grant !== second_g || s_araddr !== ((second_g == 2'b01) ? 32'h1000 : 32'h2000)) begin bad++; $display("FAIL cont_second got grant=%b addr=%h want=%b", grant, s_araddr, second_g); end
        tick();
        m_arvalid = '0; s_rvalid = 1'b1;
        #1;
        total++; if (m_rvalid !== second_g) begin bad++; $display("FAIL cont_second_r got=%b want=%b", m_rvalid, second_g); end
        tick();
        s_rvalid = 1'b0;
        $display("txn contention reads first=%b second=%b", first_g, second_g);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
`ifdef AXI_ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
        clear_inputs();
        do_reset();
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5555;
        for (int t = 0; t < 4; t++) begin
            tick();
            total++; if (grant !== exp_g[t] || s_arvalid !== 1'b1) begin bad++; $display("FAIL b2b_grant%0d got=%b arv=%b want=%b", t, grant, s_arvalid, exp_g[t]); end
            tick();
            total++; if (m_rvalid !== exp_g[t]) begin bad++; $display("FAIL b2b_r%0d got=%b want=%b", t, m_rvalid, exp_g[t]); end
            tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d got=%b want=0", t, busy); end
            $display("txn back_to_back %0d grant=%b", t, exp_g[t]);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        m_arvalid[0] = 1'b1; m_araddr[0] = 32'h3000; m_rready[0] = 1'b1; s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0; s_arready = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || s_rready !== 1'b1) begin bad++; $display("FAIL mid_in_rd_data got busy=%b rready=%b want 1/1", busy, s_rready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || grant !== 2'b00 || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin bad++; $display("FAIL mid_reset got busy=%b grant=%b rr=%b arv=%b want 0/00/0/0", busy, grant, s_rready, s_arvalid); end
        $display("txn reset during read data");
    endtask

    task automatic test_write_first();
        clear_inputs();
        do_reset();
        m_arvalid[0] = 1'b1; m_araddr[0] = 32'h4000; m_rready[0] = 1'b1;
        m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h5000; m_wvalid[0] = 1'b1; m_wdata[0] = 32'h77; m_wmask[0] = 4'hf; m_bready[0] = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        total++; if (s_awvalid !== 1'b1 || s_arvalid !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL wf_aw got awv=%b arv=%b grant=%b want 1/0/01", s_awvalid, s_arvalid, grant); end
        tick();
        m_awvalid = '0;
        #1;
        total++; if (s_wvalid !== 1'b1 || s_arvalid !== 1'b0) begin bad++; $display("FAIL wf_w got wv=%b arv=%b want 1/0", s_wvalid, s_arvalid); end
        tick();
        m_wvalid = '0; s_bvalid = 1'b1;
        #1;
        total++; if (m_bvalid !== 2'b01 || s_arvalid !== 1'b0) begin bad++; $display("FAIL wf_b got bv=%b arv=%b want 01/0", m_bvalid, s_arvalid); end
        tick();
        s_bvalid = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || s_arvalid !== 1'b0) begin bad++; $display("FAIL wf_idle got busy=%b arv=%b want 0/0", busy, s_arvalid); end
        s_arready = 1'b1;
        tick();
        total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h4000) begin bad++; $display("FAIL wf_ar got arv=%b a=%h want 1/4000", s_arvalid, s_araddr); end
        tick();
        m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1;
        #1;
        total++; if (m_rvalid !== 2'b01) begin bad++; $display("FAIL wf_r got=%b want=01", m_rvalid); end
        tick();
        clear_inputs();
        $display("txn write-then-read m0");
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_write_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
